collatz_engine: RTL
===================

# collatz_engine

Parametrised Collatz sequence engine. It accepts a seed on a start strobe and iterates the sequence internally, one operation per clock, until it reaches 1. It reports the stopping time, the peak value and error flags, and supports a standard mode and a shortcut ((3k+1)/2) mode. It replaces the fixed-width controller-plus-datapath pair as a self-contained block with a busy/done handshake.

## Interface
- N_W, default 16: seed width.
- K_W, default 20: working register width; K_W >= N_W required.
- CNT_W, default 10: step counter width.
- clk  in  1: clock, rising-edge.
- rst_n  in  1: reset, asynchronous, active-low.
- st  in  1: start strobe; sampled only in IDLE.
- md  in  1: mode, captured with the seed.
  - 0 = standard: even k -> k/2, odd k -> 3k+1.
  - 1 = shortcut: odd k -> (3k+1)/2 in one operation.
- co  in  N_W: seed, captured with st.
- bs  out  1: busy.
- done  out  1: one-cycle completion pulse.
- steps  out  CNT_W: operations performed.
- peak  out  K_W: maximum value held in k during the run, seed included.
- ovf  out  1: an odd step result exceeded K_W bits.
- tmo  out  1: step counter exhausted before reaching 1.
- err  out  1: seed was 0.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE** (bs=0, done=0)
  - On st=1: k <= zero-extended co, peak <= co, steps <= 0, ovf/tmo/err <= 0, mode <= md.
  - If co==0: go to DONE with err=1. Otherwise go to RUN.
  - Results from the previous run hold until the next accepted start.
- **RUN** (bs=1). Each cycle, evaluated in this priority order:
  1. k==1: go to DONE, no operation.
  2. steps == 2^CNT_W-1: go to DONE with tmo=1; k and steps unchanged.
  3. k even: k <= k>>1; steps+1.
  4. k odd: form t = 3k+1 at K_W+2 bits.
     - If t >= 2^K_W: go to DONE with ovf=1; k, steps and peak unchanged.
     - Otherwise k <= t (md=0) or t>>1 (md=1); steps+1; peak <= max(peak, new k).
- Peak tracks stored k values only. In shortcut mode the intermediate 3k+1 is never stored and never counted in peak.
- **DONE** (bs=0, done=1): exactly one cycle, then IDLE. st is ignored in DONE.
- st is ignored while in RUN; no queuing.
- All flags are mutually exclusive per run.

## Timing
- Reset: state=IDLE; k, steps, peak = 0; bs, done, ovf, tmo, err = 0. Takes effect immediately. Reset mid-run abandons the run with no done pulse.
- All outputs are registered (Moore); no combinational path from st, co or md to any output.
- Start accepted at edge E0 (st=1 in IDLE). bs is high from E0 until the DONE entry edge.
- Normal run of S operations: RUN lasts S+1 cycles. done is high in the cycle following edge E0+S+1.
  - co=1 gives done in cycle E1..E2 with steps=0.
- Seed 0: DONE entered at E0; done in cycle E0..E1.
- steps, peak and flags are valid when done is high and stay stable until the next accepted st.
- st held high continuously starts a new run on the edge after DONE (back-to-back runs 1 cycle apart).

## Test plan
- Standard mode, default params: co=27, md=0 -> steps=111, peak=9232, flags 0, done 112 cycles after start edge; co=6 -> steps=8, peak=16.
- Shortcut mode: co=27, md=1 -> steps=70, peak=4616; co=7, md=1 -> steps=11, peak=26.
- Overflow, K_W=8, N_W=8: co=27, md=0 -> ovf=1, steps=11, peak=214 (aborts at k=107).
- Timeout, CNT_W=4: co=27, md=0 -> tmo=1, steps=15, peak=484.
- Edge seeds: co=1 -> done at E1, steps=0, peak=1; co=0 -> err=1, done at E0, steps=0, peak=0.
- Protocol:
  - st pulsed mid-run is ignored; results are unchanged.
  - rst_n low mid-run (co=27) -> all outputs 0 immediately, no done pulse.
  - A fresh start afterwards completes normally.
  - st held high gives a restart on the cycle after done.

Source files
------------

// File: rtl/collatz_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : collatz_engine_if
//  Description : Start/result bundle between a requester and collatz_engine.
//                master drives the seed/mode/start strobe and observes the
//                busy/done handshake and the run results; slave is the engine.
//                Ports carried:
//                  st    - start strobe
//                  md    - mode (0 standard, 1 shortcut)
//                  co    - seed, N_W bits
//                  bs    - busy
//                  done  - one-cycle completion pulse
//                  steps - operations performed, CNT_W bits
//                  peak  - largest stored working value, K_W bits
//                  ovf   - odd step result exceeded K_W bits
//                  tmo   - step counter exhausted before reaching 1
//                  err   - seed was zero
//  Revision    : 1.0 - initial release
// ============================================================================
interface collatz_engine_if #(
    parameter int N_W   = 16,
    parameter int K_W   = 20,
    parameter int CNT_W = 10
) ();
    logic             st;
    logic             md;
    logic [N_W-1:0]   co;
    logic             bs;
    logic             done;
    logic [CNT_W-1:0] steps;
    logic [K_W-1:0]   peak;
    logic             ovf;
    logic             tmo;
    logic             err;

    modport master (
        output st, md, co,
        input  bs, done, steps, peak, ovf, tmo, err
    );

    modport slave (
        input  st, md, co,
        output bs, done, steps, peak, ovf, tmo, err
    );
endinterface : collatz_engine_if
`default_nettype wire

// File: rtl/collatz_engine.sv
`default_nettype none
// ============================================================================
//  Module      : collatz_engine
//  Description : Iterates the Collatz sequence from a captured seed, one
//                operation per clock, until the working value reaches 1.
//                Reports the operation count, the peak stored value and
//                mutually exclusive overflow / timeout / zero-seed flags.
//                Standard mode: even k -> k/2, odd k -> 3k+1.
//                Shortcut mode: odd k -> (3k+1)/2 in a single operation.
//                Ports:
//                  clk   - rising-edge clock
//                  rst_n - asynchronous active-low reset
//                  bus   - collatz_engine_if.slave (st/md/co in,
//                          bs/done/steps/peak/ovf/tmo/err out)
//                The interface instance must use the same N_W/K_W/CNT_W
//                values as this module; K_W must be at least N_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module collatz_engine #(
    parameter int N_W   = 16,
    parameter int K_W   = 20,
    parameter int CNT_W = 10
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    collatz_engine_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [K_W-1:0]     k_q,     k_d;
    logic [CNT_W-1:0]   steps_q, steps_d;
    logic [K_W-1:0]     peak_q,  peak_d;
    logic               mode_q,  mode_d;
    logic               ovf_q,   ovf_d;
    logic               tmo_q,   tmo_d;
    logic               err_q,   err_d;
    logic               bs_q,    bs_d;
    logic               done_q,  done_d;

    // 3k+1 is formed two bits wider than k so any overflow of the working
    // register shows up in the top two bits rather than wrapping.
    logic [K_W+1:0]     t_wide;
    logic               t_ovf;
    logic [K_W-1:0]     k_odd;

    assign t_wide = {2'b00, k_q} + {1'b0, k_q, 1'b0} + (K_W+2)'(1);
    assign t_ovf  = (t_wide[K_W+1:K_W] != 2'b00);
    // When t_ovf is clear, t_wide[K_W] is zero, so the halved value is exact.
    assign k_odd  = mode_q ? t_wide[K_W:1] : t_wide[K_W-1:0];

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        steps_d = steps_q;
        peak_d  = peak_q;
        mode_d  = mode_q;
        ovf_d   = ovf_q;
        tmo_d   = tmo_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.st) begin
                    k_d     = K_W'(bus.co);
                    peak_d  = K_W'(bus.co);
                    steps_d = '0;
                    mode_d  = bus.md;
                    ovf_d   = 1'b0;
                    tmo_d   = 1'b0;
                    err_d   = (bus.co == '0);
                    state_d = (bus.co == '0) ? S_DONE : S_RUN;
                end
            end

            S_RUN: begin
                if (k_q == K_W'(1)) begin
                    state_d = S_DONE;
                end else if (&steps_q) begin
                    // Counter saturated: stop without touching k or steps.
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end else if (!k_q[0]) begin
                    k_d     = k_q >> 1;
                    steps_d = steps_q + CNT_W'(1);
                end else if (t_ovf) begin
                    // Abort before storing; k, steps and peak keep the last
                    // value that fitted.
                    ovf_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    k_d     = k_odd;
                    steps_d = steps_q + CNT_W'(1);
                    // Halving never raises the value, so peak only needs an
                    // update on odd steps.
                    if (k_odd > peak_q) begin
                        peak_d = k_odd;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake outputs are flopped from the next state so they are pure
        // register outputs with no path from st/co/md.
        bs_d   = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            steps_q <= '0;
            peak_q  <= '0;
            mode_q  <= 1'b0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
            err_q   <= 1'b0;
            bs_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            steps_q <= steps_d;
            peak_q  <= peak_d;
            mode_q  <= mode_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            bs_q    <= bs_d;
            done_q  <= done_d;
        end
    end

    assign bus.bs    = bs_q;
    assign bus.done  = done_q;
    assign bus.steps = steps_q;
    assign bus.peak  = peak_q;
    assign bus.ovf   = ovf_q;
    assign bus.tmo   = tmo_q;
    assign bus.err   = err_q;

endmodule : collatz_engine
`default_nettype wire
